// File: rtl/psdsqrt_seq.sv
// psdsqrt_seq
// Upstream sequencer for the serial psdsqrt square-root core. Operands
// arrive on a valid/ready stream and are buffered in a small FIFO. One
// operand at a time is handed to the core with a start pulse, a stop pulse
// is issued a fixed number of cycles later, and the result is captured and
// offered downstream on a valid/ready stream together with its operand.
//
// Ports
//   clock       master clock, rising edge
//   reset       synchronous reset, active low
//   in_valid    operand offered upstream
//   in_ready    FIFO has room (fifo_count != FIFO_DEPTH)
//   in_data     operand
//   sq_start    one-cycle start pulse to the core
//   sq_stop     one-cycle stop pulse to the core
//   sq_xin      registered operand driven to the core
//   sq_sqrt     result from the core's output register
//   out_valid   result available downstream
//   out_ready   downstream accepts the result
//   out_sqrt    captured result
//   out_xin     operand that produced out_sqrt
//   busy        FSM is not idle
//   fifo_count  current FIFO occupancy

module psdsqrt_seq #(
  parameter int NUMBITS     = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SQRT_CYCLES = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUMBITS-1:0]              in_data,
  output logic                            sq_start,
  output logic                            sq_stop,
  output logic [NUMBITS-1:0]              sq_xin,
  input  logic [NUMBITS/2-1:0]            sq_sqrt,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUMBITS/2-1:0]            out_sqrt,
  output logic [NUMBITS-1:0]              out_xin,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int RW = NUMBITS / 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(SQRT_CYCLES);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  // Last counter value spent in RUN; RUN lasts SQRT_CYCLES-1 cycles so that
  // the stop pulse lands exactly SQRT_CYCLES cycles after the start pulse.
  localparam logic [TW-1:0] RUN_LAST   = TW'(SQRT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [NUMBITS-1:0] mem_q [FIFO_DEPTH];
  logic [NUMBITS-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NUMBITS-1:0] sq_xin_q, sq_xin_d;
  logic [RW-1:0]     out_sqrt_q, out_sqrt_d;
  logic [NUMBITS-1:0] out_xin_q, out_xin_d;

  logic push;
  logic pop;

  // FIFO bookkeeping and FSM next-state. in_ready is taken from the
  // registered count, so a full FIFO refuses a push even in the cycle it
  // pops (no bypass). Pointers wrap naturally because the depth is a power
  // of two.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    sq_xin_d   = sq_xin_q;
    out_sqrt_d = out_sqrt_q;
    out_xin_d  = out_xin_q;

    in_ready = (count_q != FULL_COUNT);
    push     = in_valid && in_ready;
    pop      = (state_q == S_IDLE) && (count_q != '0);

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      sq_xin_d = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == RUN_LAST) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The core loaded its output register on the stop edge, so the
        // result is stable for the whole of this cycle.
        out_sqrt_d = sq_sqrt;
        out_xin_d  = sq_xin_q;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight and discards both
  // the buffered operands and any pending result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      sq_xin_q   <= '0;
      out_sqrt_q <= '0;
      out_xin_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      sq_xin_q   <= sq_xin_d;
      out_sqrt_q <= out_sqrt_d;
      out_xin_q  <= out_xin_d;
    end
  end

  // Pulses and status are straight state decodes, so each pulse is exactly
  // one cycle wide and start/stop can never overlap.
  assign sq_start   = (state_q == S_START);
  assign sq_stop    = (state_q == S_STOP);
  assign out_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign sq_xin     = sq_xin_q;
  assign out_sqrt   = out_sqrt_q;
  assign out_xin    = out_xin_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_psdsqrt_seq.sv
// tb_psdsqrt_seq
// Self-checking bench for psdsqrt_seq. A behavioural core model answers the
// start/stop protocol with floor(sqrt(x)); accepted operands are pushed into
// a scoreboard queue and a negedge monitor compares results, pulse timing and
// FIFO occupancy against it.

module tb_psdsqrt_seq;

  localparam int NUMBITS     = 32;
  localparam int FIFO_DEPTH  = 4;
  localparam int SQRT_CYCLES = 16;
  localparam int RW          = NUMBITS / 2;
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] in_data;
  logic               sq_start;
  logic               sq_stop;
  logic [NUMBITS-1:0] sq_xin;
  logic [RW-1:0]      sq_sqrt;
  logic               out_valid;
  logic               out_ready;
  logic [RW-1:0]      out_sqrt;
  logic [NUMBITS-1:0] out_xin;
  logic               busy;
  logic [CW-1:0]      fifo_count;

  psdsqrt_seq #(
    .NUMBITS    (NUMBITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SQRT_CYCLES(SQRT_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sq_start  (sq_start),
    .sq_stop   (sq_stop),
    .sq_xin    (sq_xin),
    .sq_sqrt   (sq_sqrt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sqrt  (out_sqrt),
    .out_xin   (out_xin),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NUMBITS-1:0] xin;
    logic [RW-1:0]      root;
    int                 push_cyc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit inflight   = 0;
  int exp_stop   = -1000;
  int exp_valid  = -1000;
  int last_hs    = -1000;
  bit prev_start = 0;
  bit prev_stop  = 0;
  bit prev_valid = 0;
  bit saw_full   = 0;
  logic [NUMBITS-1:0] start_xin = '0;

  // out_ready: 0 = held low, 1 = held high, 2 = random per cycle
  int   ready_mode = 1;
  logic rnd_ready  = 1'b1;
  assign out_ready = (ready_mode == 2) ? rnd_ready : (ready_mode == 1);

  always @(posedge clock) begin
    #1;
    rnd_ready = ($urandom_range(0, 9) < 7);
  end

  // Reference: integer square root by plain trial of each result bit.
  function automatic logic [RW-1:0] isqrt(input logic [NUMBITS-1:0] x);
    longint r = 0;
    longint c;
    for (int b = RW - 1; b >= 0; b--) begin
      c = r | (longint'(1) << b);
      if (c * c <= longint'(x)) r = c;
    end
    return RW'(r);
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural core: output register shows junk while computing and loads
  // floor(sqrt(x)) on the stop edge.
  logic [NUMBITS-1:0] core_x = '0;
  initial sq_sqrt = '0;
  always @(posedge clock) begin
    if (sq_start === 1'b1) begin
      core_x = sq_xin;
      sq_sqrt <= RW'($urandom);
    end
    if (sq_stop === 1'b1) sq_sqrt <= isqrt(core_x);
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      sb_q.delete();
      inflight   = 0;
      exp_stop   = -1000;
      exp_valid  = -1000;
      prev_start = 0;
      prev_stop  = 0;
      prev_valid = 0;
    end else begin
      if (sq_start) begin
        checkOutput("start_stop_overlap", 64'(sq_stop), 64'(0));
        checkOutput("start_double", 64'(prev_start), 64'(0));
        checkOutput("start_has_work", 64'(sb_q.size() != 0 && !inflight), 64'(1));
        if (sb_q.size() != 0) begin
          checkOutput("start_time", 64'(cyc), 64'(maxi(sb_q[0].push_cyc, last_hs) + 2));
          checkOutput("start_xin", 64'(sq_xin), 64'(sb_q[0].xin));
        end
        inflight  = 1;
        exp_stop  = cyc + SQRT_CYCLES;
        exp_valid = cyc + SQRT_CYCLES + 2;
        start_xin = sq_xin;
      end else if (!inflight && sb_q.size() != 0 &&
                   cyc > maxi(sb_q[0].push_cyc, last_hs) + 2) begin
        checkOutput("start_late", 64'(cyc), 64'(maxi(sb_q[0].push_cyc, last_hs) + 2));
        last_hs = cyc;
      end

      if (sq_stop) begin
        checkOutput("stop_double", 64'(prev_stop), 64'(0));
        checkOutput("stop_time", 64'(cyc), 64'(exp_stop));
        checkOutput("stop_xin_stable", 64'(sq_xin), 64'(start_xin));
      end

      checkOutput("fifo_count", 64'(fifo_count), 64'(sb_q.size() - (inflight ? 1 : 0)));
      checkOutput("in_ready", 64'(in_ready), 64'(fifo_count != CW'(FIFO_DEPTH)));
      checkOutput("busy", 64'(busy), 64'(inflight));
      checkOutput("valid_only_with_op", 64'(out_valid && !(inflight && sb_q.size() != 0)), 64'(0));
      if (fifo_count == CW'(FIFO_DEPTH)) saw_full = 1;

      if (out_valid && !prev_valid) begin
        checkOutput("valid_rise_time", 64'(cyc), 64'(exp_valid));
        checkOutput("capture_xin_stable", 64'(sq_xin), 64'(start_xin));
      end

      if (out_valid && inflight && sb_q.size() != 0) begin
        checkOutput("out_sqrt", 64'(out_sqrt), 64'(sb_q[0].root));
        checkOutput("out_xin", 64'(out_xin), 64'(sb_q[0].xin));
        if (out_ready) begin
          void'(sb_q.pop_front());
          inflight = 0;
          last_hs  = cyc;
        end
      end

      if (in_valid && in_ready)
        sb_q.push_back('{xin: in_data, root: isqrt(in_data), push_cyc: cyc});

      prev_start = sq_start;
      prev_stop  = sq_stop;
      prev_valid = out_valid;
    end
  end

  // Offer one operand and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [NUMBITS-1:0] x);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clock);
    while (!in_ready && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("push_accept_timeout", 64'(waited < 400), 64'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    @(negedge clock);
    while ((sb_q.size() != 0 || inflight || busy) && n < bound) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_timeout", 64'(n < bound), 64'(1));
    @(posedge clock);
    #1;
  endtask

  task automatic waitValid(input int bound);
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < bound) begin
      @(negedge clock);
      n++;
    end
    checkOutput("valid_timeout", 64'(n < bound), 64'(1));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = $urandom;

    // Reset held with in_valid high: nothing may be pushed.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_fifo_count", 64'(fifo_count), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_sq_start", 64'(sq_start), 64'(0));
    checkOutput("rst_sq_stop", 64'(sq_stop), 64'(0));
    checkOutput("rst_sq_xin", 64'(sq_xin), 64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_sqrt", 64'(out_sqrt), 64'(0));
    checkOutput("rst_out_xin", 64'(out_xin), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    checkOutput("rel_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rel_fifo_count", 64'(fifo_count), 64'(0));
    @(posedge clock);
    #1;

    // Single operations including the extremes.
    $display("[TB] single operations");
    ready_mode = 1;
    applyStimulus(32'd144);
    waitIdle(100);
    applyStimulus(32'hFFFF_FFFF);
    waitIdle(100);
    applyStimulus(32'd0);
    waitIdle(100);

    // Backpressure: result held for 10 cycles with a second op queued.
    $display("[TB] backpressure");
    ready_mode = 0;
    applyStimulus(32'd100);
    applyStimulus(32'd400);
    waitValid(100);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #1;
    ready_mode = 1;
    waitIdle(200);

    // Fill the FIFO while the first op runs; results must stay in order.
    $display("[TB] fifo full and ordering");
    saw_full = 0;
    applyStimulus(32'd1);
    applyStimulus(32'd4);
    applyStimulus(32'd9);
    applyStimulus(32'd16);
    applyStimulus(32'd25);
    applyStimulus(32'd36);
    waitIdle(400);
    checkOutput("fifo_reached_full", 64'(saw_full), 64'(1));

    // Push offered in the very cycle a full FIFO pops: refused, then taken.
    $display("[TB] simultaneous push and pop");
    ready_mode = 0;
    for (int i = 0; i < 5; i++) applyStimulus($urandom);
    waitValid(100);
    @(posedge clock);
    #1;
    in_valid   = 1'b1;
    in_data    = 32'd777;
    ready_mode = 1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("pop_cycle_in_ready", 64'(in_ready), 64'(0));
    checkOutput("pop_cycle_count", 64'(fifo_count), 64'(4));
    @(negedge clock);
    checkOutput("after_pop_count", 64'(fifo_count), 64'(3));
    checkOutput("after_pop_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    waitIdle(600);

    // Reset in the middle of RUN with two operands queued.
    $display("[TB] reset mid-run");
    applyStimulus(32'd49);
    applyStimulus(32'd64);
    applyStimulus(32'd81);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_fifo_count", 64'(fifo_count), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      checkOutput("post_reset_quiet", 64'({sq_start, sq_stop, out_valid}), 64'(0));
    end
    @(posedge clock);
    #1;

    // Randomised traffic with random downstream stalls.
    $display("[TB] random traffic");
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      logic [NUMBITS-1:0] x;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
      end
      case ($urandom_range(0, 5))
        0:       x = 32'hFFFF_FFFF;
        1:       x = $urandom_range(0, 300);
        default: x = $urandom;
      endcase
      applyStimulus(x);
    end
    ready_mode = 1;
    waitIdle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
